// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//
// Bundles every handshake and memory-bus signal of mem_arbiter so the core
// side and the memory side can be wired with one connection.
//
// Signal groups:
//   fetch requester : if_req, if_addr -> if_gnt, if_valid, if_rdata
//   data requester  : d_req, d_we, d_func3, d_addr, d_wdata
//                     -> d_gnt, d_valid, d_rdata, d_err
//   memory port     : m_read, m_write, m_addr, m_func3, m_wdata <- m_rdata
//
// Modports:
//   slave  : the arbiter's view (serves the requesters, drives the memory)
//   master : the surrounding system's view (requesters plus memory)
// ---------------------------------------------------------------------------
interface mem_arbiter_if;

    // Fetch requester
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;

    // Load/store requester
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_func3;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;

    // Unified memory port
    logic        m_read;
    logic        m_write;
    logic [7:0]  m_addr;
    logic [2:0]  m_func3;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    modport slave (
        input  if_req,
        input  if_addr,
        output if_gnt,
        output if_valid,
        output if_rdata,
        input  d_req,
        input  d_we,
        input  d_func3,
        input  d_addr,
        input  d_wdata,
        output d_gnt,
        output d_valid,
        output d_rdata,
        output d_err,
        output m_read,
        output m_write,
        output m_addr,
        output m_func3,
        output m_wdata,
        input  m_rdata
    );

    modport master (
        output if_req,
        output if_addr,
        input  if_gnt,
        input  if_valid,
        input  if_rdata,
        output d_req,
        output d_we,
        output d_func3,
        output d_addr,
        output d_wdata,
        input  d_gnt,
        input  d_valid,
        input  d_rdata,
        input  d_err,
        input  m_read,
        input  m_write,
        input  m_addr,
        input  m_func3,
        input  m_wdata,
        output m_rdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares a single-port 256-byte unified memory between the instruction-fetch
// requester and the load/store requester. Every access occupies exactly one
// memory cycle:
//   edge 0 : request sampled, payload latched, *_gnt pulsed, memory driven
//   edge 1 : m_rdata captured into *_rdata, *_valid pulsed
// A new grant may be issued at the same edge that completes the previous
// access, so the memory can be busy every cycle.
//
// Data requests win over fetch, except that after FETCH_STARVE_MAX
// consecutive data grants issued while fetch is waiting, fetch gets the next
// slot.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears every output immediately
//   bus   : mem_arbiter_if.slave (requester handshakes plus memory port)
//
// Parameters:
//   FETCH_STARVE_MAX : consecutive data grants tolerated while if_req is
//                      pending (1..15)
//
// Build option:
//   MEM_ARB_ALIGN_CHECK_EN : when defined, misaligned halfword/word data
//                            accesses are granted but never reach the
//                            memory; they complete with d_err=1 and
//                            d_rdata=0. When undefined d_err stays 0 and all
//                            addresses are forwarded unchanged.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned FETCH_STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_MAX_C = 4'(FETCH_STARVE_MAX);
    localparam logic [2:0] FUNC3_WORD_C = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACC_I = 2'b01,
        ACC_D = 2'b10
    } state_t;

    state_t      state_r;
    logic [3:0]  starve_r;   // data grants issued while fetch kept waiting
    logic        we_r;       // access in flight is a store
    logic        misal_r;    // access in flight was rejected as misaligned

    logic        grant_d_s;
    logic        grant_i_s;
    logic        misal_s;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    // Halfword codes need an even address, word needs a multiple of four;
    // byte accesses and undefined codes are never flagged.
    function automatic logic is_misaligned(input logic [2:0] func3,
                                           input logic [7:0] addr);
        logic bad;
        case (func3)
            3'b001, 3'b101: bad = addr[0];
            3'b010:         bad = (addr[1:0] != 2'b00);
            default:        bad = 1'b0;
        endcase
        return bad;
    endfunction
`endif

    // Slot owner for the next cycle: data unless fetch has been starved long
    // enough; a request still high right after its grant counts as a new one.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (bus.d_req && (!bus.if_req || (starve_r < STARVE_MAX_C))) begin
            grant_d_s = 1'b1;
        end else if (bus.if_req) begin
            grant_i_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Alignment classification of the data payload currently presented.
    always_comb begin
        misal_s = 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        misal_s = is_misaligned(bus.d_func3, bus.d_addr);
`endif
    end

    // Arbiter FSM: grants, memory drive, response capture and starve count,
    // all registered so every output is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            starve_r     <= 4'd0;
            we_r         <= 1'b0;
            misal_r      <= 1'b0;
            bus.if_gnt   <= 1'b0;
            bus.if_valid <= 1'b0;
            bus.if_rdata <= 32'd0;
            bus.d_gnt    <= 1'b0;
            bus.d_valid  <= 1'b0;
            bus.d_rdata  <= 32'd0;
            bus.d_err    <= 1'b0;
            bus.m_read   <= 1'b0;
            bus.m_write  <= 1'b0;
            bus.m_addr   <= 8'd0;
            bus.m_func3  <= FUNC3_WORD_C;
            bus.m_wdata  <= 32'd0;
        end else begin
            // Pulses default low; m_addr/m_func3/m_wdata hold when idle.
            bus.if_gnt   <= 1'b0;
            bus.d_gnt    <= 1'b0;
            bus.if_valid <= 1'b0;
            bus.d_valid  <= 1'b0;
            bus.d_err    <= 1'b0;
            bus.m_read   <= 1'b0;
            bus.m_write  <= 1'b0;

            // Complete the access that occupied the memory this cycle.
            case (state_r)
                ACC_I: begin
                    bus.if_rdata <= bus.m_rdata;
                    bus.if_valid <= 1'b1;
                end
                ACC_D: begin
                    bus.d_valid <= 1'b1;
                    if (misal_r) begin
`ifdef MEM_ARB_ALIGN_CHECK_EN
                        bus.d_err <= 1'b1;
`else
                        bus.d_err <= 1'b0;
`endif
                        bus.d_rdata <= 32'd0;
                    end else if (!we_r) begin
                        bus.d_rdata <= bus.m_rdata;
                    end else begin
                        // Stores leave the last load result visible.
                        bus.d_rdata <= bus.d_rdata;
                    end
                end
                default: begin
                    bus.if_rdata <= bus.if_rdata;
                    bus.d_rdata  <= bus.d_rdata;
                end
            endcase

            // Start the next access, possibly back-to-back.
            if (grant_d_s) begin
                state_r     <= ACC_D;
                bus.d_gnt   <= 1'b1;
                we_r        <= bus.d_we;
                misal_r     <= misal_s;
                bus.m_addr  <= bus.d_addr;
                bus.m_func3 <= bus.d_func3;
                bus.m_wdata <= bus.d_wdata;
                // A rejected access must leave the memory untouched.
                bus.m_read  <= ~bus.d_we & ~misal_s;
                bus.m_write <= bus.d_we & ~misal_s;
            end else if (grant_i_s) begin
                state_r     <= ACC_I;
                bus.if_gnt  <= 1'b1;
                we_r        <= 1'b0;
                misal_r     <= 1'b0;
                bus.m_addr  <= bus.if_addr;
                bus.m_func3 <= FUNC3_WORD_C;
                bus.m_read  <= 1'b1;
            end else begin
                state_r     <= IDLE;
                we_r        <= 1'b0;
                misal_r     <= 1'b0;
            end

            // Starvation tracking only matters while fetch is waiting.
            if (grant_d_s && bus.if_req) begin
                if (starve_r >= STARVE_MAX_C) begin
                    starve_r <= STARVE_MAX_C;
                end else begin
                    starve_r <= starve_r + 4'd1;
                end
            end else if (grant_i_s || !bus.if_req) begin
                starve_r <= 4'd0;
            end else begin
                starve_r <= starve_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int MAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.FETCH_STARVE_MAX(MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- memory behind the arbiter ----------------
    logic [7:0] mem [256];
    logic       bd_init;
    logic       bd_we;
    logic [7:0] bd_addr;
    logic [7:0] bd_data;

    function automatic logic [31:0] extend(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic [2:0] f);
        case (f)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b100:  return {24'd0, b0};
            3'b101:  return {16'd0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    assign bus.m_rdata = extend(mem[bus.m_addr], mem[8'(bus.m_addr + 8'd1)],
                                mem[8'(bus.m_addr + 8'd2)], mem[8'(bus.m_addr + 8'd3)],
                                bus.m_func3);

    always @(posedge clk) begin
        if (bd_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (bus.m_write) begin
            mem[bus.m_addr] <= bus.m_wdata[7:0];
            if (bus.m_func3[1:0] != 2'b00) mem[8'(bus.m_addr + 8'd1)] <= bus.m_wdata[15:8];
            if (bus.m_func3[1:0] == 2'b10) begin
                mem[8'(bus.m_addr + 8'd2)] <= bus.m_wdata[23:16];
                mem[8'(bus.m_addr + 8'd3)] <= bus.m_wdata[31:24];
            end
        end
    end

    // ---------------- reference model state ----------------
    logic [7:0]  ref_mem [256];
    bit          pend_i, pend_d;
    logic [7:0]  qi_addr, qd_addr;
    logic        qd_we;
    logic [2:0]  qd_f3;
    logic [31:0] qd_wd;
    int          consec;          // data grants in a row while fetch waited
    int          exp_kind;        // 0 none, 1 fetch, 2 data: response due next edge
    logic [31:0] exp_val;
    bit          exp_err, exp_store;
    logic [31:0] exp_if_rdata, exp_d_rdata;
    bit          pst_valid;       // store whose commit is due before the next access
    logic [7:0]  pst_addr;
    logic [2:0]  pst_f3;
    logic [31:0] pst_data;
    int          vectors = 0;
    int          miscompares = 0;
    logic [1:0]  seq [10];
    logic [2:0]  ld_codes [5];
    logic [2:0]  st_codes [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [2:0] f);
        return extend(ref_mem[a], ref_mem[8'(a + 8'd1)], ref_mem[8'(a + 8'd2)],
                      ref_mem[8'(a + 8'd3)], f);
    endfunction

    function automatic bit misaligned(input logic [2:0] f, input logic [7:0] a);
`ifdef MEM_ARB_ALIGN_CHECK_EN
        return ((f == 3'b001 || f == 3'b101) && a[0]) || (f == 3'b010 && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic ref_store(input logic [7:0] a, input logic [2:0] f, input logic [31:0] d);
        int n;
        n = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[8'(a + 8'(k))] = d[8*k +: 8];
    endtask

    task automatic drive();
        bus.if_req  = pend_i;
        bus.if_addr = qi_addr;
        bus.d_req   = pend_d;
        bus.d_we    = qd_we;
        bus.d_func3 = qd_f3;
        bus.d_addr  = qd_addr;
        bus.d_wdata = qd_wd;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        ref_mem[a] = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic set_data(input logic we, input logic [2:0] f, input logic [7:0] a,
                            input logic [31:0] wd);
        pend_d  = 1'b1;
        qd_we   = we;
        qd_f3   = f;
        qd_addr = a;
        qd_wd   = wd;
    endtask

    // One clock: predict the slot owner from the priority rules, then check
    // the completed response and the new grant/memory drive after the edge.
    task automatic tick();
        bit gd, gi, erd, ewr, nerr;
        logic [7:0]  ea;
        logic [2:0]  ef;
        logic [31:0] nv;
        if (pst_valid) begin
            ref_store(pst_addr, pst_f3, pst_data);
            pst_valid = 1'b0;
        end
        drive();
        gd = pend_d && (!pend_i || consec < MAX);
        gi = !gd && pend_i;
        erd = 1'b0; ewr = 1'b0; nerr = 1'b0; nv = 32'd0; ea = 8'd0; ef = 3'b010;
        if (gd) begin
            nerr = misaligned(qd_f3, qd_addr);
            ea = qd_addr;
            ef = qd_f3;
            if (!nerr && qd_we) begin
                ewr = 1'b1;
                pst_valid = 1'b1; pst_addr = qd_addr; pst_f3 = qd_f3; pst_data = qd_wd;
            end else if (!nerr) begin
                erd = 1'b1;
                nv  = ref_load(qd_addr, qd_f3);
            end
            consec = pend_i ? ((consec + 1 > MAX) ? MAX : consec + 1) : 0;
        end else if (gi) begin
            ea = qi_addr;
            erd = 1'b1;
            nv = ref_load(qi_addr, 3'b010);
            consec = 0;
        end else if (!pend_i) begin
            consec = 0;
        end
        @(posedge clk); #1;
        if (exp_kind == 1) exp_if_rdata = exp_val;
        if (exp_kind == 2 && exp_err) exp_d_rdata = 32'd0;
        else if (exp_kind == 2 && !exp_store) exp_d_rdata = exp_val;
        check("if_valid", 32'(bus.if_valid), 32'(exp_kind == 1));
        check("d_valid",  32'(bus.d_valid),  32'(exp_kind == 2));
        check("if_rdata", bus.if_rdata, exp_if_rdata);
        check("d_rdata",  bus.d_rdata,  exp_d_rdata);
        check("d_err",    32'(bus.d_err), 32'(exp_kind == 2 && exp_err));
        check("if_gnt",   32'(bus.if_gnt), 32'(gi));
        check("d_gnt",    32'(bus.d_gnt),  32'(gd));
        check("m_read",   32'(bus.m_read), 32'(erd));
        check("m_write",  32'(bus.m_write), 32'(ewr));
        if (gd || gi) begin
            check("m_addr",  32'(bus.m_addr),  32'(ea));
            check("m_func3", 32'(bus.m_func3), 32'(ef));
        end
        if (ewr) check("m_wdata", bus.m_wdata, qd_wd);
        exp_kind  = gd ? 2 : (gi ? 1 : 0);
        exp_val   = nv;
        exp_err   = nerr;
        exp_store = gd && qd_we;
        if (gd) pend_d = 1'b0;
        if (gi) pend_i = 1'b0;
    endtask

    task automatic model_reset();
        pend_i = 1'b0; pend_d = 1'b0;
        consec = 0; exp_kind = 0; exp_err = 1'b0; exp_store = 1'b0; exp_val = 32'd0;
        exp_if_rdata = 32'd0; exp_d_rdata = 32'd0; pst_valid = 1'b0;
    endtask

    initial begin
        seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_codes = '{3'b000, 3'b001, 3'b010};
        reset = 1'b1; bd_init = 1'b0; bd_we = 1'b0; bd_addr = 8'd0; bd_data = 8'd0;
        qi_addr = 8'd0; qd_addr = 8'd0; qd_we = 1'b0; qd_f3 = 3'b010; qd_wd = 32'd0;
        model_reset();
        drive();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        bd_init = 1'b1;
        @(posedge clk); #1;
        bd_init = 1'b0;
        poke(8'h04, 8'h83); poke(8'h05, 8'h20); poke(8'h06, 8'h80); poke(8'h07, 8'h0c);
        poke(8'hC8, 8'd17); poke(8'hC9, 8'd0);  poke(8'hCA, 8'd0);  poke(8'hCB, 8'd0);
        poke(8'hD8, 8'h60); poke(8'hD9, 8'h34); poke(8'hDA, 8'hF2);

        // Reset values
        check("rst_if_gnt",  32'(bus.if_gnt),  32'd0);
        check("rst_d_gnt",   32'(bus.d_gnt),   32'd0);
        check("rst_valids",  32'({bus.if_valid, bus.d_valid}), 32'd0);
        check("rst_m_rw",    32'({bus.m_read, bus.m_write}),   32'd0);
        check("rst_d_err",   32'(bus.d_err),   32'd0);
        check("rst_if_rdata", bus.if_rdata, 32'd0);
        check("rst_d_rdata",  bus.d_rdata,  32'd0);
        check("rst_m_addr",  32'(bus.m_addr),  32'd0);
        check("rst_m_wdata", bus.m_wdata, 32'd0);
        check("rst_m_func3", 32'(bus.m_func3), 32'd2);
        reset = 1'b0;
        tick();

        // Fetch only
        pend_i = 1'b1; qi_addr = 8'h04;
        tick();
        check("fetch_gnt",   32'(bus.if_gnt), 32'd1);
        check("fetch_maddr", 32'(bus.m_addr), 32'h04);
        tick();
        check("fetch_valid", 32'(bus.if_valid), 32'd1);
        check("fetch_rdata", bus.if_rdata, 32'h0c802083);

        // Contention: both held continuously
        for (int k = 0; k < 10; k++) begin
            pend_i = 1'b1; qi_addr = 8'h10;
            set_data(1'b0, 3'b010, 8'hC8, 32'd0);
            tick();
            check("contention_grant", 32'({bus.d_gnt, bus.if_gnt}), 32'(seq[k]));
        end
        pend_i = 1'b0; pend_d = 1'b0;
        tick();
        check("contention_rdata", bus.d_rdata, 32'd17);
        tick();

        // Store then load
        set_data(1'b1, 3'b010, 8'hD4, 32'h0000002A);
        tick();
        check("st_mwrite", 32'(bus.m_write), 32'd1);
        set_data(1'b0, 3'b100, 8'hD4, 32'd0);
        tick();
        tick();
        check("ld_after_st", bus.d_rdata, 32'h2A);
        tick();

        // Reset during a store
        set_data(1'b1, 3'b010, 8'hD8, 32'h12345678);
        tick();
        reset = 1'b1;
        #1;
        check("rst_mid_mwrite", 32'(bus.m_write), 32'd0);
        check("rst_mid_drdata", bus.d_rdata, 32'd0);
        check("rst_mid_maddr",  32'(bus.m_addr), 32'd0);
        model_reset();
        drive();
        @(posedge clk); #1;
        check("rst_mid_no_valid", 32'(bus.d_valid), 32'd0);
        check("rst_mid_mem", 32'(mem[8'hD8]), 32'h60);
        reset = 1'b0;
        tick();

        // Misaligned halfword load
        set_data(1'b0, 3'b001, 8'hD9, 32'd0);
        tick();
        tick();
`ifdef MEM_ARB_ALIGN_CHECK_EN
        check("misal_err",   32'(bus.d_err), 32'd1);
        check("misal_rdata", bus.d_rdata, 32'd0);
`else
        check("misal_err",   32'(bus.d_err), 32'd0);
        check("misal_rdata", bus.d_rdata, 32'hFFFFF234);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if (!pend_i && $urandom_range(0, 2) != 0) begin
                pend_i = 1'b1;
                qi_addr = 8'($urandom_range(0, 255));
            end
            if (!pend_d && $urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 2) == 0)
                    set_data(1'b1, st_codes[$urandom_range(0, 2)],
                             8'($urandom_range(0, 255)), $urandom);
                else
                    set_data(1'b0, ld_codes[$urandom_range(0, 4)],
                             8'($urandom_range(0, 255)), $urandom);
            end
            tick();
        end
        pend_i = 1'b0; pend_d = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter that shares the unified 256-byte instruction/data memory between the instruction-fetch requester and the load/store requester. It sits between the core pipeline and the memory, and serialises every access into a one-cycle memory slot. Data accesses have priority, with a bounded-starvation guarantee for fetch. Read results come back through a registered response.

## Interface
Parameters:
- `FETCH_STARVE_MAX`, default 4: maximum number of consecutive data grants issued while `if_req` is pending; range 1–15.

Ports (`name  direction  width  meaning`):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held high with stable `if_addr` until `if_gnt`.
- `if_addr`  in  8  fetch byte address.
- `if_gnt`  out  1  one-cycle pulse: fetch request accepted.
- `if_valid`  out  1  one-cycle pulse: `if_rdata` valid.
- `if_rdata`  out  32  fetched word, little-endian.
- `d_req`  in  1  data request; held high with stable payload until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_func3`  in  3  RISC-V width/sign code (lb, lh, lw, lbu, lhu; sb, sh, sw).
- `d_addr`  in  8  data byte address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  one-cycle pulse: data request accepted.
- `d_valid`  out  1  one-cycle pulse: load data returned or store completed.
- `d_rdata`  out  32  load result, already sign- or zero-extended by the memory.
- `d_err`  out  1  misaligned-access flag; see Configuration.
- `m_read`  out  1  memory read enable.
- `m_write`  out  1  memory write enable; the memory commits on the rising edge that ends the cycle.
- `m_addr`  out  8  memory byte address.
- `m_func3`  out  3  memory width code; forced to 3'b010 for fetch.
- `m_wdata`  out  32  memory write data.
- `m_rdata`  in  32  memory combinational read data.

## Operation
- FSM states:
  - IDLE: no access in flight.
  - ACC_I: fetch access in progress.
  - ACC_D: data access in progress.
- Transitions from IDLE or ACC_x at a clock edge:
  - `d_req` high and (`if_req` low or starve count < `FETCH_STARVE_MAX`) → latch the data payload, go to ACC_D, pulse `d_gnt`.
  - Else if `if_req` high → latch `if_addr`, go to ACC_I, pulse `if_gnt`.
  - Else → IDLE.
- Starve counter:
  - Increments on each data grant issued while `if_req` is high.
  - Clears on a fetch grant or on any edge where `if_req` is low.
  - Saturates at `FETCH_STARVE_MAX`.
- Memory drive, from latched payload registers only:
  - ACC_I: `m_read`=1, `m_func3`=3'b010.
  - ACC_D: `m_read`=~we, `m_write`=we.
  - IDLE: `m_read`=`m_write`=0; `m_addr`/`m_func3`/`m_wdata` hold their last values.
- Response at the edge ending ACC_x:
  - Capture `m_rdata` into `if_rdata` or `d_rdata` and pulse the matching `*_valid`.
  - For stores, `d_rdata` is unchanged.
- Addresses pass through unmodified. Wrap past 255 is the memory's behaviour; the arbiter does not check or alter it.
- Requester rule: in the cycle `*_gnt` is high, the requester either drops `req` or presents the next payload. A `req` still high at the following edge is treated as a new request.

## Timing
- Reset values: state=IDLE; all `*_gnt`, `*_valid`, `m_read`, `m_write`, `d_err`=0; `if_rdata`, `d_rdata`, `m_addr`, `m_wdata`=0; `m_func3`=3'b010; starve counter=0.
- Latency:
  - Cycle 0: `req` sampled high at the edge ending cycle 0.
  - Cycle 1: `gnt` high and memory accessed.
  - Cycle 2: `valid` high with data.
- Throughput: one access per cycle; back-to-back grants are allowed with no idle bubble.
- Simultaneous `if_req` and `d_req`: data wins, subject to the starvation bound. After `FETCH_STARVE_MAX` consecutive data grants, the next grant goes to fetch.
- Reset asserted mid-access:
  - Outputs drop to reset values immediately (asynchronously), including `m_write`, so no partial store completes after reset.
  - No `valid` is issued for the aborted access.

## Configuration
- `MEM_ARB_ALIGN_CHECK_EN`, defined:
  - A data access is misaligned when it is halfword (func3 001/101) with `d_addr[0]`=1, or word (010) with `d_addr[1:0]`≠0.
  - A misaligned access is still granted, but in its ACC_D cycle `m_read`=`m_write`=0.
  - At the next edge, `d_valid`=1, `d_err`=1 and `d_rdata`=0.
  - Fetch is never checked.
- `MEM_ARB_ALIGN_CHECK_EN`, undefined:
  - `d_err` is tied to 0.
  - All addresses are forwarded unchanged to the memory.

## Test plan
- Fetch only: `if_req`, `if_addr`=0x04; memory word at 4 = 0x0c802083 → `if_gnt` in cycle 1, `m_read`=1 with `m_addr`=0x04, then `if_valid` with `if_rdata`=0x0c802083 in cycle 2.
- Contention: `if_req` and `d_req` (lw 0xC8, value 17) held continuously, `FETCH_STARVE_MAX`=4 → grant sequence D,D,D,D,I,D,…; `d_rdata`=17 on each `d_valid`.
- Store then load: sw 0x0000002A to 0xD4, then lbu 0xD4 → `m_write` high exactly one cycle; the next `d_valid` returns `d_rdata`=0x2A.
- Reset during an ACC_D store to 0xD8 → `m_write` falls in the same cycle, no `d_valid`; memory byte 0xD8 keeps 0x60.
- Misaligned lh at 0xD9: with `MEM_ARB_ALIGN_CHECK_EN` → `d_err`=1, `d_rdata`=0, no `m_read`; without the macro → `d_err`=0 and `d_rdata` is the memory's lh result at 0xD9.
